// File: rtl/logistic_argmax.sv
// logistic_argmax: final stage of the logistic-regression inference path.
// Latches one vector of IEEE-754 single-precision logits, walks it one logit
// per cycle, and emits the index of the largest value. No FP core is used.
// The ordering is a sign-magnitude integer compare on the raw bit patterns.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   input_logits[N_CLASSES]     logit vector; class k is input_logits[k]
//   input_logits_stb / _ack     input handshake (ack registered)
//   output_prediction           argmax index (registered)
//   output_prediction_stb/_ack  output handshake (stb registered)

// Combinational "a strictly greater than b" on float bit patterns.
// NaN flags are reported separately so the caller decides NaN policy.
module logistic_argmax_cmp (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        gt,
  output logic        a_nan,
  output logic        b_nan
);
  assign a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
  assign b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);

  always_comb begin
    gt = 1'b0;
    // +0 and -0 compare equal, so neither is greater.
    if (a[30:0] != 31'd0 || b[30:0] != 31'd0) begin
      unique case ({a[31], b[31]})
        2'b00:   gt = a[30:0] > b[30:0];
        2'b11:   gt = a[30:0] < b[30:0];
        2'b01:   gt = 1'b1;
        default: gt = 1'b0;
      endcase
    end
  end
endmodule

module logistic_argmax #(
  parameter int N_CLASSES = 3,
  parameter int IDX_W     = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CLASSES-1:0][31:0] input_logits,
  input  logic                       input_logits_stb,
  output logic                       input_logits_ack,
  output logic [IDX_W-1:0]           output_prediction,
  output logic                       output_prediction_stb,
  input  logic                       output_prediction_ack
);
  typedef enum logic [1:0] {GET, COMPARE, PUT} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CLASSES - 1);

  state_t                     state, state_nxt;
  logic [N_CLASSES-1:0][31:0] logits_q;
  logic [31:0]                best_val;
  logic [IDX_W-1:0]           best_idx;
  logic [IDX_W-1:0]           i;

  logic [31:0] cand;
  logic        cand_gt, cand_nan, best_nan;
  logic        replace;
  logic        accept, handoff;

  assign cand = logits_q[i];

  logistic_argmax_cmp u_cmp (
    .a     (cand),
    .b     (best_val),
    .gt    (cand_gt),
    .a_nan (cand_nan),
    .b_nan (best_nan)
  );

  // A NaN candidate never wins; a NaN incumbent loses to any non-NaN, which
  // makes the first non-NaN logit win when logit 0 is NaN.
  assign replace = !cand_nan && (best_nan || cand_gt);
  assign accept  = (state == GET) && input_logits_stb && input_logits_ack;
  assign handoff = (state == PUT) && output_prediction_stb && output_prediction_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= GET;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      GET:     if (accept) state_nxt = (N_CLASSES == 1) ? PUT : COMPARE;
      COMPARE: if (i == LAST) state_nxt = PUT;
      PUT:     if (handoff) state_nxt = GET;
      default: state_nxt = GET;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      logits_q              <= '0;
      best_val              <= '0;
      best_idx              <= '0;
      i                     <= '0;
      input_logits_ack      <= 1'b0;
      output_prediction     <= '0;
      output_prediction_stb <= 1'b0;
    end else begin
      unique case (state)
        GET: begin
          if (accept) begin
            logits_q         <= input_logits;
            best_val         <= input_logits[0];
            best_idx         <= '0;
            i                <= IDX_W'(1);
            input_logits_ack <= 1'b0;
            if (N_CLASSES == 1) begin
              output_prediction     <= '0;
              output_prediction_stb <= 1'b1;
            end
          end else begin
            // Ready rises on the first edge after reset and stays up in GET.
            input_logits_ack <= 1'b1;
          end
        end
        COMPARE: begin
          if (replace) begin
            best_val <= cand;
            best_idx <= i;
          end
          i <= i + IDX_W'(1);
          if (i == LAST) begin
            // Fold in the last compare so the result is out this same edge.
            output_prediction     <= replace ? i : best_idx;
            output_prediction_stb <= 1'b1;
          end
        end
        PUT: begin
          if (handoff) begin
            output_prediction_stb <= 1'b0;
            input_logits_ack      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_logistic_argmax.sv
module tb_logistic_argmax;
  localparam int N = 3;
  localparam int IW = 2;

  typedef struct {
    logic [N-1:0][31:0] lg;
    logic [IW-1:0]      exp;
    string              name;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0][31:0] logits;
  logic               in_stb;
  logic               in_ack;
  logic [IW-1:0]      pred;
  logic               out_stb;
  logic               out_ack;

  int n_chk = 0;
  int n_fail = 0;

  vec_t vecs[10];

  logistic_argmax #(.N_CLASSES(N), .IDX_W(IW)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .input_logits          (logits),
    .input_logits_stb      (in_stb),
    .input_logits_ack      (in_ack),
    .output_prediction     (pred),
    .output_prediction_stb (out_stb),
    .output_prediction_ack (out_ack)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [31:0] k0, k1, k2, input logic [IW-1:0] e, input string nm);
    vec_t v;
    v.lg   = {k2, k1, k0};
    v.exp  = e;
    v.name = nm;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Present a vector and let it be accepted; returns at the negedge after the
  // accept edge with stb dropped and the input bus scribbled over.
  task automatic accept(input logic [N-1:0][31:0] lg, input string nm);
    int n = 0;
    while (!in_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_ready"}, 32'(in_ack), 32'd1);
    logits = lg;
    in_stb = 1'b1;
    @(negedge clk);
    in_stb = 1'b0;
    logits = {N{32'h7F7FFFFF}};
  endtask

  // Full transaction with out_ack held high.
  task automatic run_vec(input vec_t v);
    accept(v.lg, v.name);
    chk({v.name, "_ack_low"}, 32'(in_ack), 32'd0);
    chk({v.name, "_stb_e1"}, 32'(out_stb), 32'd0);
    @(negedge clk);
    chk({v.name, "_stb_e2"}, 32'(out_stb), 32'd0);
    @(negedge clk);
    chk({v.name, "_stb_e3"}, 32'(out_stb), 32'd1);
    chk({v.name, "_pred"}, 32'(pred), 32'(v.exp));
    @(negedge clk);
    chk({v.name, "_stb_drop"}, 32'(out_stb), 32'd0);
    chk({v.name, "_ready_again"}, 32'(in_ack), 32'd1);
    chk({v.name, "_pred_hold"}, 32'(pred), 32'(v.exp));
  endtask

  initial begin
    vecs[0] = mk(32'h40A00000, 32'h41300000, 32'h40800000, 2'd1, "basic");
    vecs[1] = mk(32'hBF800000, 32'hC0400000, 32'hBF000000, 2'd2, "all_neg");
    vecs[2] = mk(32'h40000000, 32'h40000000, 32'h3F800000, 2'd0, "tie");
    vecs[3] = mk(32'h80000000, 32'h00000000, 32'hFF800000, 2'd0, "zero_tie");
    vecs[4] = mk(32'h7FC00000, 32'h3F800000, 32'hBF800000, 2'd1, "nan0");
    vecs[5] = mk(32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 2'd0, "all_nan");
    vecs[6] = mk(32'h3F800000, 32'h7F800000, 32'h7FC00000, 2'd1, "inf_nan");
    vecs[7] = mk(32'h00000000, 32'h00000001, 32'h80000001, 2'd1, "denorm");
    vecs[8] = mk(32'hFFC00000, 32'hC0000000, 32'hBF800000, 2'd2, "nan0_neg");
    vecs[9] = mk(32'hC0000000, 32'h80000000, 32'h3F000000, 2'd2, "mixed");

    rst = 1'b1; in_stb = 1'b0; logits = '0; out_ack = 1'b1;
    @(negedge clk);
    chk("rst_ack", 32'(in_ack), 32'd0);
    chk("rst_stb", 32'(out_stb), 32'd0);
    chk("rst_pred", 32'(pred), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ack", 32'(in_ack), 32'd1);

    for (int k = 0; k < 10; k++) run_vec(vecs[k]);

    // Backpressure: out_ack low for 5 cycles once stb is up.
    out_ack = 1'b0;
    accept(vecs[0].lg, "bp");
    @(negedge clk);
    @(negedge clk);
    chk("bp_stb_up", 32'(out_stb), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_stb_hold", 32'(out_stb), 32'd1);
      chk("bp_pred_hold", 32'(pred), 32'd1);
      chk("bp_ack_low", 32'(in_ack), 32'd0);
    end
    out_ack = 1'b1;
    @(negedge clk);
    chk("bp_stb_drop", 32'(out_stb), 32'd0);
    chk("bp_ready", 32'(in_ack), 32'd1);

    // Back-to-back with in_stb held high; the second vector must wait for GET.
    logits = vecs[0].lg;
    in_stb = 1'b1;
    @(negedge clk);
    chk("b2b_ack0", 32'(in_ack), 32'd0);
    logits = vecs[1].lg;
    @(negedge clk);
    chk("b2b_stb_e2", 32'(out_stb), 32'd0);
    @(negedge clk);
    chk("b2b_stb_a", 32'(out_stb), 32'd1);
    chk("b2b_pred_a", 32'(pred), 32'd1);
    @(negedge clk);
    chk("b2b_gap_stb", 32'(out_stb), 32'd0);
    chk("b2b_gap_ack", 32'(in_ack), 32'd1);
    @(negedge clk);
    chk("b2b_ack1", 32'(in_ack), 32'd0);
    in_stb = 1'b0;
    logits = {N{32'h7F7FFFFF}};
    @(negedge clk);
    chk("b2b_stb_e5", 32'(out_stb), 32'd0);
    @(negedge clk);
    chk("b2b_stb_b", 32'(out_stb), 32'd1);
    chk("b2b_pred_b", 32'(pred), 32'd2);
    @(negedge clk);

    // Reset one cycle after acceptance aborts with no result.
    accept(vecs[0].lg, "rst_mid");
    rst = 1'b1;
    #1;
    chk("rstm_ack", 32'(in_ack), 32'd0);
    chk("rstm_stb", 32'(out_stb), 32'd0);
    chk("rstm_pred", 32'(pred), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rstm_stb_hold", 32'(out_stb), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstm_rel_ack", 32'(in_ack), 32'd1);
    chk("rstm_rel_stb", 32'(out_stb), 32'd0);
    run_vec(vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/logistic_argmax.md
# logistic_argmax

Final stage of the logistic-regression inference path: consumes the logit vector produced by the matrix-multiply stage (one IEEE-754 single-precision logit per class) and emits the index of the largest logit as the class prediction. It drives the `output_prediction` / `output_prediction_stb` / `output_prediction_ack` port of `logistic_predict`. Comparison is sequential, one logit per cycle, with no floating-point core instantiated.

## Interface
- `N_CLASSES`, default 3: number of logits and classes; must be ≥ 1.
- `IDX_W`, default 2: width of the prediction index; `IDX_W = max(1, $clog2(N_CLASSES))`.

Ports:
- `clk`, input, 1: clock. One clock domain; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `input_logits`, input, `[N_CLASSES-1:0][31:0]`: logits. Class k is `input_logits[k]`.
- `input_logits_stb`, input, 1: upstream has valid logits.
- `input_logits_ack`, output, 1: block is ready to accept logits.
- `output_prediction`, output, `IDX_W`: argmax class index.
- `output_prediction_stb`, output, 1: prediction valid.
- `output_prediction_ack`, input, 1: downstream accepts the prediction.

## Operation
- FSM states: GET, COMPARE, PUT.
- **GET**
  - `input_logits_ack` = 1.
  - On an edge with `input_logits_stb & input_logits_ack`:
    - Latch the whole vector.
    - `best_val` ← logit 0, `best_idx` ← 0, `i` ← 1.
    - `input_logits_ack` ← 0.
    - Go to COMPARE, or straight to PUT if `N_CLASSES == 1`.
- **COMPARE**, one logit per cycle:
  - If logit `i` is strictly greater than `best_val`, replace both `best_val` and `best_idx`.
  - `i` ← `i+1`.
  - After logit `N_CLASSES-1` has been compared: `output_prediction` ← final `best_idx`, `output_prediction_stb` ← 1, go to PUT.
- **PUT**
  - Hold `output_prediction` and `output_prediction_stb`.
  - On an edge with `output_prediction_stb & output_prediction_ack`: `output_prediction_stb` ← 0, `input_logits_ack` ← 1, go to GET.
- **Greater-than rules** (sign-magnitude integer compare on the 32-bit pattern):
  - Both non-negative: larger magnitude wins.
  - Both negative: smaller magnitude wins.
  - Positive beats negative.
  - +0 and −0 are equal.
  - ±Inf and denormals fall out of the bit compare naturally.
  - NaN (exponent all-ones, mantissa ≠ 0) is never greater, and is never replaced-into.
    - If logit 0 is NaN, the first non-NaN logit is taken unconditionally.
    - If all logits are NaN, the result is 0.
  - Ties: the lowest index wins, because replacement requires strictly greater.
- Latched logits are used throughout. Changes on `input_logits` after acceptance have no effect.

## Timing
- **Reset** (asserted asynchronously): state = GET, `input_logits_ack` = 0, `output_prediction_stb` = 0, `output_prediction` = 0. Internal `best_*` and `i` are cleared.
- **First cycle after reset release**: `input_logits_ack` rises at the first rising edge with `rst` low, so it is visible 1 cycle after release.
- **Registered outputs**: all outputs are registered; no combinational path from inputs to outputs.
- **Latency**: accept edge E → `output_prediction_stb` high after edge E + (N_CLASSES−1).
  - N_CLASSES = 3: stb high 2 cycles after acceptance.
  - N_CLASSES = 1: stb high immediately after E.
- **Output handshake**: after the ack edge, `input_logits_ack` is high on the next cycle. Throughput is 1 vector per N_CLASSES+1 cycles with `output_prediction_ack` held high.
- **Output stability**:
  - `output_prediction` is stable while `output_prediction_stb` is high.
  - `output_prediction` holds its value after the handshake, until the next result.
- **Input handshake**: `input_logits_stb` held high continuously is legal; each GET visit accepts exactly one vector.
- **`input_logits_stb` outside GET**: ignored.
- **Reset mid-COMPARE or mid-PUT**: abort immediately to the reset values. No partial result is emitted.

## Test plan
- **Basic:** logits {k0=0x40A00000 (5.0), k1=0x41300000 (11.0), k2=0x40800000 (4.0)}, ack held high.
  - `output_prediction` = 1.
  - stb high exactly 2 cycles after the accept edge, for 1 cycle.
- **All negative:** {0xBF800000 (−1.0), 0xC0400000 (−3.0), 0xBF000000 (−0.5)} → 2.
- **Ties:**
  - {0x40000000, 0x40000000, 0x3F800000} → 0.
  - {0x80000000 (−0), 0x00000000 (+0), 0xFF800000 (−Inf)} → 0.
- **NaN:**
  - {0x7FC00000, 0x3F800000, 0xBF800000} → 1.
  - All 0x7FC00000 → 0.
  - {0x3F800000, 0x7F800000 (+Inf), 0x7FC00000} → 1.
- **Backpressure:** hold `output_prediction_ack` low for 5 cycles after stb rises.
  - stb and prediction stay stable and `input_logits_ack` stays 0.
  - Raise ack: stb falls next edge and `input_logits_ack` = 1 the following cycle.
  - Two back-to-back vectors (expected results 1 then 2) come out in order.
- **Reset:**
  - Assert `rst` one cycle after acceptance: all outputs 0 immediately, no stb appears.
  - After release: `input_logits_ack` = 1 after 1 cycle, and a new vector (expected result 2) completes correctly.
